// File: rtl/rr_timeout_arbiter_if.sv
// Request/grant bundle between the NoC output-stage arbiter and its input ports.
// The arbiter takes the slave side; the port logic (or a bench) takes the master side.
interface rr_timeout_arbiter_if #(
  parameter int NUM_PORTS = 5,
  parameter int LEN_W     = 12,
  parameter int FLIT_ID_W = 3,
  parameter int IDX_W     = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]           req;
  logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id;
  logic [NUM_PORTS*LEN_W-1:0]     length;
  logic [NUM_PORTS-1:0]           grant;
  logic                           grant_valid;
  logic [IDX_W-1:0]               grant_idx;
  logic [NUM_PORTS-1:0]           timeout_pulse;

  modport master (
    output req, flit_id, length,
    input  grant, grant_valid, grant_idx, timeout_pulse
  );

  modport slave (
    input  req, flit_id, length,
    output grant, grant_valid, grant_idx, timeout_pulse
  );
endinterface

// File: rtl/rr_timeout_arbiter.sv
// N-port round-robin arbiter with a per-port hold limit latched from header flits.
// Registered one-hot grant drives the crossbar select.
//
// state   | meaning
// S_IDLE  | no owner; any request is granted starting after the last owner
// S_GRANT | idx_q owns the output; held until release or hold-limit expiry
module rr_timeout_arbiter #(
  parameter  int NUM_PORTS = 5,
  parameter  int LEN_W     = 12,
  parameter  int FLIT_ID_W = 3,
  parameter  int HEAD_ID   = 1,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_timeout_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [NUM_PORTS-1:0]   tpulse_q, tpulse_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic [LEN_W-1:0]       limit_q [NUM_PORTS];

  logic [LEN_W-1:0]       owner_limit;
  logic                   expired;
  logic [IDX_W:0]         nxt_idle, nxt_own;

  // Rotating search from p+1. From idle the previous owner is the last candidate,
  // so a lone requester is still served; while owning, p itself is excluded.
  function automatic logic [IDX_W:0] search(input logic [IDX_W-1:0]   p,
                                            input logic [NUM_PORTS-1:0] r,
                                            input logic                 incl_self);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      j = (int'(p) + k) % NUM_PORTS;
      if (!found && r[j[IDX_W-1:0]] && (k < NUM_PORTS || incl_self)) begin
        found = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) limit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (bus.flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(HEAD_ID))
          limit_q[i] <= bus.length[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      tpulse_q <= '0;
      idx_q    <= '0;
      last_q   <= IDX_W'(NUM_PORTS - 1);
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      tpulse_q <= tpulse_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    tpulse_d    = '0;
    idx_d       = idx_q;
    last_d      = last_q;
    count_d     = count_q;
    owner_limit = limit_q[idx_q];
    expired     = (owner_limit != '0) && (count_q == owner_limit - 1'b1);
    nxt_idle    = search(last_q, bus.req, 1'b1);
    nxt_own     = search(idx_q, bus.req, 1'b0);

    case (state_q)
      S_IDLE: begin
        if (nxt_idle[IDX_W]) begin
          state_d                        = S_GRANT;
          grant_d                        = '0;
          grant_d[nxt_idle[IDX_W-1:0]]   = 1'b1;
          idx_d                          = nxt_idle[IDX_W-1:0];
          count_d                        = '0;
        end
      end
      S_GRANT: begin
        if (!bus.req[idx_q]) begin
          last_d = idx_q;
          if (nxt_own[IDX_W]) begin
            grant_d                     = '0;
            grant_d[nxt_own[IDX_W-1:0]] = 1'b1;
            idx_d                       = nxt_own[IDX_W-1:0];
            count_d                     = '0;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (expired) begin
          // With no competitor the owner keeps the output and simply restarts its window.
          count_d = '0;
          if (nxt_own[IDX_W]) begin
            grant_d                     = '0;
            grant_d[nxt_own[IDX_W-1:0]] = 1'b1;
            idx_d                       = nxt_own[IDX_W-1:0];
            last_d                      = idx_q;
            tpulse_d[idx_q]             = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = |grant_q;
  assign bus.grant_idx     = idx_q;
  assign bus.timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Directed bench for rr_timeout_arbiter: a 5-port/12-bit instance and an 8-port/4-bit instance.
module tb_rr_timeout_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  rr_timeout_arbiter_if #(.NUM_PORTS(5), .LEN_W(12), .FLIT_ID_W(3)) bus_a ();
  rr_timeout_arbiter_if #(.NUM_PORTS(8), .LEN_W(4),  .FLIT_ID_W(3)) bus_b ();

  rr_timeout_arbiter #(.NUM_PORTS(5), .LEN_W(12), .FLIT_ID_W(3), .HEAD_ID(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  rr_timeout_arbiter #(.NUM_PORTS(8), .LEN_W(4), .FLIT_ID_W(3), .HEAD_ID(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // {grant, grant_valid, grant_idx, timeout_pulse}
  logic [13:0] obs_a, exp_a;
  logic [19:0] obs_b, exp_b;
  assign obs_a = {bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, bus_a.timeout_pulse};
  assign obs_b = {bus_b.grant, bus_b.grant_valid, bus_b.grant_idx, bus_b.timeout_pulse};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_limit_a(input int port, input logic [11:0] val);
    bus_a.flit_id[port*3 +: 3]  = 3'd1;
    bus_a.length[port*12 +: 12] = val;
    tick();
    bus_a.flit_id = '0;
  endtask

  task automatic load_all_a(input logic [11:0] val);
    for (int i = 0; i < 5; i++) begin
      bus_a.flit_id[i*3 +: 3]  = 3'd1;
      bus_a.length[i*12 +: 12] = val;
    end
    tick();
    bus_a.flit_id = '0;
  endtask

  task automatic load_all_b(input logic [3:0] val);
    for (int i = 0; i < 8; i++) begin
      bus_b.flit_id[i*3 +: 3] = 3'd1;
      bus_b.length[i*4 +: 4]  = val;
    end
    tick();
    bus_b.flit_id = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.req = '0; bus_a.flit_id = '0; bus_a.length = '0;
    bus_b.req = '0; bus_b.flit_id = '0; bus_b.length = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_a = '0;
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL reset_a: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    exp_b = '0;
    n_checks++;
    if (obs_b !== exp_b) $display("FAIL reset_b: got %h expected %h", obs_b, exp_b);
    else n_pass++;
  endtask

  task automatic test_basic();
    bus_a.req = 5'b10100;
    tick();
    exp_a = {5'b00100, 1'b1, 3'd2, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL basic_first: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = 5'b10000;
    tick();
    exp_a = {5'b10000, 1'b1, 3'd4, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL basic_release: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = '0;
    tick();
    exp_a = {5'b0, 1'b0, 3'd4, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL basic_idle: got %h expected %h", obs_a, exp_a);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int owner, prev;
    load_all_a(12'd3);
    bus_a.req = 5'b11111;
    prev = 0;
    for (int s = 0; s < 6; s++) begin
      owner = s % 5;
      for (int c = 0; c < 3; c++) begin
        tick();
        exp_a = {5'(1 << owner), 1'b1, 3'(owner),
                 (c == 0 && s > 0) ? 5'(1 << prev) : 5'b0};
        n_checks++;
        if (obs_a !== exp_a)
          $display("FAIL fairness s%0d c%0d: got %h expected %h", s, c, obs_a, exp_a);
        else n_pass++;
      end
      prev = owner;
    end
    bus_a.req = '0;
    tick();
    exp_a = {5'b0, 1'b0, 3'd0, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL fairness_release: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    load_all_a(12'd0);
  endtask

  task automatic test_unlimited();
    bus_a.req = 5'b00010;
    tick();
    exp_a = {5'b00010, 1'b1, 3'd1, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL unlimited_first: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = 5'b00011;
    for (int i = 0; i < 120; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL unlimited_hold c%0d: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
    end
    bus_a.req = 5'b00001;
    tick();
    exp_a = {5'b00001, 1'b1, 3'd0, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL unlimited_handover: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = '0;
    tick();
  endtask

  task automatic test_lone_expiry();
    load_limit_a(3, 12'd2);
    bus_a.req = 5'b01000;
    exp_a = {5'b01000, 1'b1, 3'd3, 5'b0};
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL lone_expiry c%0d: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
    end
    bus_a.req = '0;
    tick();
  endtask

  task automatic test_idle_rotation();
    bus_a.req = 5'b00100;
    tick();
    exp_a = {5'b00100, 1'b1, 3'd2, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL rot_grant2: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = '0;
    exp_a = {5'b0, 1'b0, 3'd2, 5'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL rot_idle c%0d: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
    end
    bus_a.req = 5'b01001;
    exp_a = {5'b01000, 1'b1, 3'd3, 5'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL rot_grant3 c%0d: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
    end
    tick();
    exp_a = {5'b00001, 1'b1, 3'd0, 5'b01000};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL rot_preempt: got %h expected %h", obs_a, exp_a);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bus_a.req = '0;
    tick();
    load_limit_a(0, 12'd2);
    load_limit_a(4, 12'd5);
    bus_a.req = 5'b10000;
    exp_a = {5'b10000, 1'b1, 3'd4, 5'b0};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL mrst_owner4 c%0d: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_a = '0;
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL mrst_drop: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    // limit[0] was 2 before reset; holding well past 2 cycles shows it was cleared
    bus_a.req = 5'b00011;
    exp_a = {5'b00001, 1'b1, 3'd0, 5'b0};
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) $display("FAIL mrst_limits c%0d: got %h expected %h", i, obs_a, exp_a);
      else n_pass++;
    end
    bus_a.req = '0;
    tick();
  endtask

  task automatic test_head_on_expiry();
    load_limit_a(1, 12'd2);
    bus_a.req = 5'b00010;
    tick();
    exp_a = {5'b00010, 1'b1, 3'd1, 5'b0};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL head_exp_first: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = 5'b00011;
    tick();
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL head_exp_hold: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.flit_id[3 +: 3]  = 3'd1;
    bus_a.length[12 +: 12] = 12'd0;
    tick();
    bus_a.flit_id = '0;
    exp_a = {5'b00001, 1'b1, 3'd0, 5'b00010};
    n_checks++;
    if (obs_a !== exp_a) $display("FAIL head_exp_old_limit: got %h expected %h", obs_a, exp_a);
    else n_pass++;
    bus_a.req = '0;
    tick();
  endtask

  task automatic test_sweep_basic();
    bus_b.req = 8'b00010100;
    tick();
    exp_b = {8'b00000100, 1'b1, 3'd2, 8'b0};
    n_checks++;
    if (obs_b !== exp_b) $display("FAIL sweep_first: got %h expected %h", obs_b, exp_b);
    else n_pass++;
    bus_b.req = 8'b00010000;
    tick();
    exp_b = {8'b00010000, 1'b1, 3'd4, 8'b0};
    n_checks++;
    if (obs_b !== exp_b) $display("FAIL sweep_release: got %h expected %h", obs_b, exp_b);
    else n_pass++;
    bus_b.req = '0;
    tick();
    exp_b = {8'b0, 1'b0, 3'd4, 8'b0};
    n_checks++;
    if (obs_b !== exp_b) $display("FAIL sweep_idle: got %h expected %h", obs_b, exp_b);
    else n_pass++;
  endtask

  task automatic test_sweep_fairness();
    int owner, prev;
    load_all_b(4'd15);
    bus_b.req = 8'hFF;
    prev = 0;
    // last owner was port 4, so rotation starts at port 5
    for (int s = 0; s < 9; s++) begin
      owner = (5 + s) % 8;
      for (int c = 0; c < 15; c++) begin
        tick();
        exp_b = {8'(1 << owner), 1'b1, 3'(owner),
                 (c == 0 && s > 0) ? 8'(1 << prev) : 8'b0};
        n_checks++;
        if (obs_b !== exp_b)
          $display("FAIL sweep_fair s%0d c%0d: got %h expected %h", s, c, obs_b, exp_b);
        else n_pass++;
      end
      prev = owner;
    end
    bus_b.req = '0;
    tick();
    exp_b = {8'b0, 1'b0, 3'd5, 8'b0};
    n_checks++;
    if (obs_b !== exp_b) $display("FAIL sweep_fair_release: got %h expected %h", obs_b, exp_b);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    test_reset();
    test_basic();
    test_fairness();
    test_unlimited();
    test_lone_expiry();
    test_idle_rotation();
    test_mid_reset();
    test_head_on_expiry();
    test_sweep_basic();
    test_sweep_fairness();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
